// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA cores: FSM encoding, fixed AXI4 attributes and
// the word-to-byte shift used for strides and burst sizes.
package vdma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StRun,
        StDrain
    } vdma_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32    = 3'b010;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
    localparam int unsigned STRIDE_SHIFT  = 2;

    function automatic logic [31:0] burst_bytes(input logic [31:0] awlen);
        return (awlen + 32'd1) << STRIDE_SHIFT;
    endfunction

endpackage

// File: rtl/vdma_axi4_aw_gen.sv
// Strided 2-D burst address generator: walks bursts along a line, then jumps to the
// next line base. Shared between the read and write VDMA cores.
module vdma_axi4_aw_gen
    import vdma_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int STRIDE_WIDTH = 12,
    parameter int H_WIDTH      = 12,
    parameter int V_WIDTH      = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_run,
    input  logic                    i_stall,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [STRIDE_WIDTH-1:0] i_stride,
    input  logic [H_WIDTH-1:0]      i_width,
    input  logic [V_WIDTH-1:0]      i_height,
    input  logic [LEN_WIDTH-1:0]    i_awlen,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic                    o_awvalid,
    output logic                    o_done
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_stride_bytes;
    logic [H_WIDTH-1:0]    r_width;
    logic [H_WIDTH:0]      r_hcnt;
    logic [V_WIDTH-1:0]    r_vcnt;
    logic                  r_active;

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_stride_bytes;
    logic [H_WIDTH:0]      w_burst_words;
    logic [H_WIDTH:0]      w_hcnt_next;
    logic                  w_line_end;
    logic                  w_aw_hs;

    assign w_step         = ADDR_WIDTH'(burst_bytes(32'(i_awlen)));
    assign w_stride_bytes = ADDR_WIDTH'(i_stride) << STRIDE_SHIFT;
    assign w_burst_words  = (H_WIDTH + 1)'(i_awlen) + (H_WIDTH + 1)'(1);
    assign w_hcnt_next    = r_hcnt - w_burst_words;
    // r_hcnt counts words left in the line, including the burst being offered
    assign w_line_end     = (w_burst_words >= r_hcnt);

    assign o_awvalid = r_active & i_run & ~i_stall;
    assign o_awaddr  = r_addr;
    assign o_done    = ~r_active;
    assign w_aw_hs   = o_awvalid & i_awready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr         <= '0;
            r_base         <= '0;
            r_stride_bytes <= '0;
            r_width        <= '0;
            r_hcnt         <= '0;
            r_vcnt         <= '0;
            r_active       <= 1'b0;
        end else if (i_start) begin
            r_addr         <= i_addr;
            r_base         <= i_addr + w_stride_bytes;
            r_stride_bytes <= w_stride_bytes;
            r_width        <= i_width;
            r_hcnt         <= {1'b0, i_width};
            r_vcnt         <= i_height;
            r_active       <= (i_width != '0) && (i_height != '0);
        end else if (w_aw_hs) begin
            if (w_line_end) begin
                r_addr <= r_base;
                r_base <= r_base + r_stride_bytes;
                r_hcnt <= {1'b0, r_width};
                r_vcnt <= r_vcnt - V_WIDTH'(1);
                if (r_vcnt == V_WIDTH'(1)) begin
                    r_active <= 1'b0;
                end
            end else begin
                r_addr <= r_addr + w_step;
                r_hcnt <= w_hcnt_next;
            end
        end
    end

endmodule

// File: rtl/vdma_axi4s_to_axi4_core.sv
// Video write DMA: syncs to frame start on an AXI4-Stream input and writes pixels to a
// strided frame buffer as AXI4 INCR bursts; AW may run ahead of W by a credit count.
module vdma_axi4s_to_axi4_core
    import vdma_pkg::*;
#(
    parameter int AXI4_ID_WIDTH    = 6,
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_LEN_WIDTH   = 8,
    parameter int AXI4S_USER_WIDTH = 1,
    parameter int AXI4S_DATA_WIDTH = 24,
    parameter int STRIDE_WIDTH     = 12,
    parameter int H_WIDTH          = 12,
    parameter int V_WIDTH          = 12,
    parameter int INDEX_WIDTH      = 8,
    parameter int CREDIT_WIDTH     = 4
) (
    input  logic                        i_aclk,
    input  logic                        i_aresetn,
    input  logic                        i_enable,
    output logic                        o_busy,
    input  logic [AXI4_ADDR_WIDTH-1:0]  i_param_addr,
    input  logic [STRIDE_WIDTH-1:0]     i_param_stride,
    input  logic [H_WIDTH-1:0]          i_param_width,
    input  logic [V_WIDTH-1:0]          i_param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]   i_param_awlen,
    output logic [INDEX_WIDTH-1:0]      o_status_index,
    output logic                        o_status_err,
    output logic [AXI4_ID_WIDTH-1:0]    o_m_axi4_awid,
    output logic [AXI4_ADDR_WIDTH-1:0]  o_m_axi4_awaddr,
    output logic [AXI4_LEN_WIDTH-1:0]   o_m_axi4_awlen,
    output logic [1:0]                  o_m_axi4_awburst,
    output logic [2:0]                  o_m_axi4_awsize,
    output logic [3:0]                  o_m_axi4_awcache,
    output logic                        o_m_axi4_awlock,
    output logic [2:0]                  o_m_axi4_awprot,
    output logic [3:0]                  o_m_axi4_awqos,
    output logic [3:0]                  o_m_axi4_awregion,
    output logic                        o_m_axi4_awvalid,
    input  logic                        i_m_axi4_awready,
    output logic [31:0]                 o_m_axi4_wdata,
    output logic [3:0]                  o_m_axi4_wstrb,
    output logic                        o_m_axi4_wlast,
    output logic                        o_m_axi4_wvalid,
    input  logic                        i_m_axi4_wready,
    input  logic [AXI4_ID_WIDTH-1:0]    i_m_axi4_bid,
    input  logic [1:0]                  i_m_axi4_bresp,
    input  logic                        i_m_axi4_bvalid,
    output logic                        o_m_axi4_bready,
    input  logic [AXI4S_USER_WIDTH-1:0] i_s_axi4s_tuser,
    input  logic                        i_s_axi4s_tlast,
    input  logic [AXI4S_DATA_WIDTH-1:0] i_s_axi4s_tdata,
    input  logic                        i_s_axi4s_tvalid,
    output logic                        o_s_axi4s_tready
);

    vdma_state_e               r_state;
    vdma_state_e               w_state_next;
    logic [CREDIT_WIDTH-1:0]   r_credit;
    logic [CREDIT_WIDTH-1:0]   r_outstanding;
    logic [AXI4_LEN_WIDTH-1:0] r_beat;
    logic [AXI4_LEN_WIDTH-1:0] r_awlen;
    logic [INDEX_WIDTH-1:0]    r_index;
    logic                      r_err;
    logic                      r_first;

    logic                      w_start;
    logic                      w_run;
    logic                      w_credit_nz;
    logic                      w_stall;
    logic                      w_aw_done;
    logic                      w_aw_hs;
    logic                      w_wvalid;
    logic                      w_wlast;
    logic                      w_w_hs;
    logic                      w_wlast_hs;
    logic                      w_b_hs;
    logic [CREDIT_WIDTH-1:0]   w_credit_d;
    logic [CREDIT_WIDTH-1:0]   w_out_d;
    logic                      w_unused;

    assign w_start     = (r_state == StIdle) && i_enable;
    assign w_run       = (r_state == StRun);
    assign w_credit_nz = (r_credit != '0);
    // Outstanding shares the counter width, so it also gates AW to avoid wrapping
    assign w_stall     = (&r_credit) | (&r_outstanding);
    assign w_wvalid    = w_run & i_s_axi4s_tvalid & w_credit_nz;
    assign w_wlast     = (r_beat == r_awlen);
    assign w_w_hs      = w_wvalid & i_m_axi4_wready;
    assign w_wlast_hs  = w_w_hs & w_wlast;
    assign w_aw_hs     = o_m_axi4_awvalid & i_m_axi4_awready;
    assign w_b_hs      = i_m_axi4_bvalid & o_m_axi4_bready;
    assign w_credit_d  = r_credit + CREDIT_WIDTH'(w_aw_hs) - CREDIT_WIDTH'(w_wlast_hs);
    assign w_out_d     = r_outstanding + CREDIT_WIDTH'(w_aw_hs) - CREDIT_WIDTH'(w_b_hs);
    assign w_unused    = ^{i_m_axi4_bid, i_s_axi4s_tlast, i_s_axi4s_tuser};

    assign o_busy            = (r_state != StIdle);
    assign o_status_index    = r_index;
    assign o_status_err      = r_err;
    assign o_m_axi4_awid     = '0;
    assign o_m_axi4_awlen    = r_awlen;
    assign o_m_axi4_awburst  = AXI_BURST_INCR;
    assign o_m_axi4_awsize   = AXI_SIZE_32;
    assign o_m_axi4_awcache  = AXI_CACHE_DEF;
    assign o_m_axi4_awlock   = 1'b0;
    assign o_m_axi4_awprot   = 3'b000;
    assign o_m_axi4_awqos    = 4'h0;
    assign o_m_axi4_awregion = 4'h0;
    assign o_m_axi4_wdata    = {{(32 - AXI4S_DATA_WIDTH){1'b0}}, i_s_axi4s_tdata};
    assign o_m_axi4_wstrb    = 4'hf;
    assign o_m_axi4_wlast    = w_run & w_wlast;
    assign o_m_axi4_wvalid   = w_wvalid;
    assign o_m_axi4_bready   = o_busy;

    vdma_axi4_aw_gen #(
        .ADDR_WIDTH   (AXI4_ADDR_WIDTH),
        .LEN_WIDTH    (AXI4_LEN_WIDTH),
        .STRIDE_WIDTH (STRIDE_WIDTH),
        .H_WIDTH      (H_WIDTH),
        .V_WIDTH      (V_WIDTH)
    ) u_aw_gen (
        .i_clk     (i_aclk),
        .i_rst_n   (i_aresetn),
        .i_start   (w_start),
        .i_run     (w_run),
        .i_stall   (w_stall),
        .i_addr    (i_param_addr),
        .i_stride  (i_param_stride),
        .i_width   (i_param_width),
        .i_height  (i_param_height),
        .i_awlen   (r_awlen),
        .i_awready (i_m_axi4_awready),
        .o_awaddr  (o_m_axi4_awaddr),
        .o_awvalid (o_m_axi4_awvalid),
        .o_done    (w_aw_done)
    );

    always_comb begin
        w_state_next     = r_state;
        o_s_axi4s_tready = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_enable) w_state_next = StSync;
            end
            StSync: begin
                // Hold off the frame-start beat so RUN writes it as the first pixel
                o_s_axi4s_tready = ~i_s_axi4s_tuser[0];
                if (i_s_axi4s_tvalid && i_s_axi4s_tuser[0]) w_state_next = StRun;
            end
            StRun: begin
                o_s_axi4s_tready = i_m_axi4_wready & w_credit_nz;
                if (w_wlast_hs && w_aw_done && (r_credit == CREDIT_WIDTH'(1))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_out_d == '0) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state       <= StIdle;
            r_credit      <= '0;
            r_outstanding <= '0;
            r_beat        <= '0;
            r_awlen       <= '0;
            r_index       <= '0;
            r_err         <= 1'b0;
            r_first       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_awlen       <= i_param_awlen;
                r_index       <= r_index + INDEX_WIDTH'(1);
                r_err         <= 1'b0;
                r_credit      <= '0;
                r_outstanding <= '0;
                r_beat        <= '0;
            end else begin
                r_credit      <= w_credit_d;
                r_outstanding <= w_out_d;
                if (w_w_hs) begin
                    r_beat <= w_wlast ? '0 : r_beat + AXI4_LEN_WIDTH'(1);
                end
                if ((w_w_hs && i_s_axi4s_tuser[0] && !r_first) ||
                    (w_b_hs && (i_m_axi4_bresp != 2'b00))) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == StSync) && (w_state_next == StRun)) begin
                r_first <= 1'b1;
            end else if (w_w_hs) begin
                r_first <= 1'b0;
            end
        end
    end

endmodule
